// File: rtl/seq_skip_adder_pkg.sv
// Shared types and defaults for the multi-cycle carry-skip adder.
package seq_skip_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        BLK_KILL,
        BLK_GEN,
        BLK_PROP
    } gkp_t;

    function automatic gkp_t classify(input logic p, input logic ripple_cout);
        if (p)
            return BLK_PROP;
        else if (ripple_cout)
            return BLK_GEN;
        else
            return BLK_KILL;
    endfunction

endpackage

// File: rtl/seq_skip_adder_skip_block.sv
// One carry-skip block: BLK_W-bit ripple adder plus group-propagate bypass of the carry.
module skip_block
    import seq_skip_adder_pkg::*;
#(
    parameter int BLK_W = DEF_BLK_W
) (
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             cin,
    output logic [BLK_W-1:0] sum,
    output logic             cout,
    output logic             p
);

    logic [BLK_W-1:0] prop;
    logic [BLK_W:0]   c;
    gkp_t             cls;

    always_comb begin
        prop = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLK_W; i++)
            c[i+1] = (a[i] & b[i]) | (prop[i] & c[i]);
        sum = prop ^ c[BLK_W-1:0];
        p   = &prop;
        // With P=0 the ripple carry-out no longer depends on cin, so it is a pure G/K decision.
        cls  = classify(p, c[BLK_W]);
        cout = 1'b0;
        unique case (cls)
            BLK_PROP: cout = cin;
            BLK_GEN:  cout = 1'b1;
            default:  cout = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_skip_adder.sv
// Sequential carry-skip adder: resolves one BLK_W-bit block per cycle with valid/ready handshakes.
// state | meaning
// IDLE  | ready for an operand pair
// RUN   | resolving block blk_idx from the registered carry
// DONE  | result held until the consumer accepts it
module seq_skip_adder
    import seq_skip_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK_W = DEF_BLK_W
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [WIDTH-1:0]                     a_i,
    input  logic [WIDTH-1:0]                     b_i,
    input  logic                                 cin_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [WIDTH-1:0]                     sum_o,
    output logic                                 cout_o,
    output logic                                 ovf_o,
    output logic [$clog2(WIDTH/BLK_W+1)-1+1-1+1-1:0] skip_cnt_o
);

    localparam int NBLK  = WIDTH / BLK_W;
    localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int CNT_W = $clog2(NBLK) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [IDX_W-1:0] blk_idx;

    logic [BLK_W-1:0] blk_a, blk_b, blk_sum;
    logic             blk_cout, blk_p;

    always_comb begin
        blk_a = a_q[blk_idx*BLK_W +: BLK_W];
        blk_b = b_q[blk_idx*BLK_W +: BLK_W];
    end

    skip_block #(.BLK_W(BLK_W)) u_blk (
        .a    (blk_a),
        .b    (blk_b),
        .cin  (carry_q),
        .sum  (blk_sum),
        .cout (blk_cout),
        .p    (blk_p)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            blk_idx     <= '0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            sum_o       <= '0;
            cout_o      <= 1'b0;
            ovf_o       <= 1'b0;
            skip_cnt_o  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        a_q        <= a_i;
                        b_q        <= b_i;
                        carry_q    <= cin_i;
                        blk_idx    <= '0;
                        skip_cnt_o <= '0;
                        sum_o      <= '0;
                        cout_o     <= 1'b0;
                        ovf_o      <= 1'b0;
                        in_ready_o <= 1'b0;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_o[blk_idx*BLK_W +: BLK_W] <= blk_sum;
                    carry_q    <= blk_cout;
                    skip_cnt_o <= skip_cnt_o + CNT_W'(blk_p);
                    if (blk_idx == IDX_W'(NBLK - 1)) begin
                        cout_o      <= blk_cout;
                        ovf_o       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (blk_sum[BLK_W-1] != a_q[WIDTH-1]);
                        out_valid_o <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        blk_idx <= blk_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_skip_adder.sv
// Self-checking bench for seq_skip_adder: directed table, random vs. arithmetic model, stall and reset sequences.
module tb_seq_skip_adder;

    localparam int W    = 32;
    localparam int NBLK = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [W-1:0]  a_i = '0, b_i = '0;
    logic          cin_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [W-1:0]  sum_o;
    logic          cout_o, ovf_o;
    logic [3:0]    skip_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    seq_skip_adder #(.WIDTH(W), .BLK_W(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o),
        .ovf_o       (ovf_o),
        .skip_cnt_o  (skip_cnt_o)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [3:0]   skip;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range check, per-block XOR inspection.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] s, output logic co, output logic ov,
                         output logic [3:0] sk);
        longint unsigned u;
        longint          sv;
        logic [W-1:0]    x;
        u  = longint'(a) + longint'(b) + longint'(cin);
        s  = u[W-1:0];
        co = u[W];
        sv = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        x  = a ^ b;
        sk = '0;
        for (int k = 0; k < NBLK; k++)
            if (((x >> (4 * k)) & 32'hF) == 32'hF) sk = sk + 1'b1;
    endtask

    // Issues one operation, waits (bounded) for out_valid, returns results and handshake latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic [W-1:0] s, output logic co, output logic ov,
                          output logic [3:0] sk, output int lat);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!in_ready_o && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        a_i = a; b_i = b; cin_i = cin; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        lat = 1;
        @(negedge clk_i);
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        if (!out_valid_o) chk("out_valid_timeout", 64'd0, 64'd1);
        s = sum_o; co = cout_o; ov = ovf_o; sk = skip_cnt_o;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
    endtask

    initial begin
        logic [W-1:0] s, es, held_s;
        logic         co, ov, eco, eov, held_co, held_ov;
        logic [3:0]   sk, esk, held_sk;
        int           lat;
        bit           saw_valid;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4'd6};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 4'd8};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 4'd0};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4'd7};
        vecs[5] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 4'd8};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 4'd0};

        #12 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_sum", 64'(sum_o), 64'd0);
        chk("rst_flags", {62'd0, cout_o, ovf_o}, 64'd0);
        chk("rst_skip", 64'(skip_cnt_o), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, sk, lat);
            chk($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].cout));
            chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].ovf));
            chk($sformatf("vec%0d_skip", i), 64'(sk), 64'(vecs[i].skip));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NBLK + 1));
        end

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            // Bias some vectors toward long propagate chains.
            if (i % 4 == 1) rb = ~ra ^ (32'h1 << $urandom_range(0, 31));
            if (i % 4 == 3) rb = ~ra;
            model(ra, rb, rc, es, eco, eov, esk);
            run_op(ra, rb, rc, s, co, ov, sk, lat);
            chk($sformatf("rnd%0d_sum", i), 64'(s), 64'(es));
            chk($sformatf("rnd%0d_cout", i), 64'(co), 64'(eco));
            chk($sformatf("rnd%0d_ovf", i), 64'(ov), 64'(eov));
            chk($sformatf("rnd%0d_skip", i), 64'(sk), 64'(esk));
        end

        // Stall in DONE with a competing operand pair on the input.
        model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, es, eco, eov, esk);
        @(negedge clk_i);
        a_i = 32'h1234_5678; b_i = 32'h0FED_CBA9; cin_i = 1'b1; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 a_i = 32'h7FFF_0000; b_i = 32'h7FFF_0000; cin_i = 1'b0;
        lat = 1;
        @(negedge clk_i);
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        chk("stall_latency", 64'(lat), 64'(NBLK + 1));
        held_s = sum_o; held_co = cout_o; held_ov = ovf_o; held_sk = skip_cnt_o;
        chk("stall_sum", 64'(held_s), 64'(es));
        chk("stall_skip", 64'(held_sk), 64'(esk));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk($sformatf("stall%0d_valid", c), 64'(out_valid_o), 64'd1);
            chk($sformatf("stall%0d_ready", c), 64'(in_ready_o), 64'd0);
            chk($sformatf("stall%0d_sum", c), 64'(sum_o), 64'(es));
            chk($sformatf("stall%0d_flags", c), {62'd0, cout_o, ovf_o}, {62'd0, eco, eov});
            chk($sformatf("stall%0d_skip", c), 64'(skip_cnt_o), 64'(esk));
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        @(negedge clk_i);
        chk("stall_release_ready", 64'(in_ready_o), 64'd1);
        chk("stall_release_valid", 64'(out_valid_o), 64'd0);
        repeat (12) begin
            @(negedge clk_i);
            chk("stall_no_capture", 64'(out_valid_o), 64'd0);
        end

        // Reset pulse during the fourth RUN cycle.
        @(negedge clk_i);
        a_i = 32'h0F0F_0F0F; b_i = 32'h3333_3333; cin_i = 1'b1; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_ready", 64'(in_ready_o), 64'd1);
        chk("midrst_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_sum", 64'(sum_o), 64'd0);
        chk("midrst_flags", {62'd0, cout_o, ovf_o}, 64'd0);
        chk("midrst_skip", 64'(skip_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        saw_valid = 1'b0;
        repeat (15) begin
            @(negedge clk_i);
            if (out_valid_o) saw_valid = 1'b1;
        end
        chk("midrst_no_valid", 64'(saw_valid), 64'd0);
        chk("midrst_idle", 64'(in_ready_o), 64'd1);

        model(32'hDEAD_BEEF, 32'h2152_4110, 1'b1, es, eco, eov, esk);
        run_op(32'hDEAD_BEEF, 32'h2152_4110, 1'b1, s, co, ov, sk, lat);
        chk("post_rst_sum", 64'(s), 64'(es));
        chk("post_rst_cout", 64'(co), 64'(eco));
        chk("post_rst_skip", 64'(sk), 64'(esk));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/seq_skip_adder.md
SEQ_SKIP_ADDER -- requirements
Module: seq_skip_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits; SHALL be a multiple of BLK_W.
REQ-002 SHALL have parameter BLK_W, default 4: carry-skip block width; one block is resolved per cycle.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid_i, input, 1: operand pair valid.
REQ-006 SHALL have port in_ready_o, output, 1: block can accept an operand pair.
REQ-007 SHALL have port a_i, input, WIDTH: signed operand A.
REQ-008 SHALL have port b_i, input, WIDTH: signed operand B.
REQ-009 SHALL have port cin_i, input, 1: carry-in; sampled with the operands.
REQ-010 SHALL have port out_valid_o, output, 1: result valid.
REQ-011 SHALL have port out_ready_i, input, 1: consumer accepts the result.
REQ-012 SHALL have port sum_o, output, WIDTH: two's-complement sum.
REQ-013 SHALL have port cout_o, output, 1: carry out of the MSB.
REQ-014 SHALL have port ovf_o, output, 1: signed overflow.
REQ-015 SHALL have port skip_cnt_o, output, $clog2(WIDTH/BLK_W)+1: number of blocks whose carry took the skip path.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL assert in_ready_o only in IDLE.
REQ-018 SHALL, in IDLE on in_valid_i=1, capture a_i, b_i and cin_i, clear the block index and skip_cnt, and go to RUN.
REQ-019 SHALL, in RUN, resolve block k (bits k*BLK_W+BLK_W-1 : k*BLK_W) each cycle from the registered carry, write its sum bits, and register its carry-out.
REQ-020 SHALL classify each block by group propagate P = AND of (a^b) over the block.
REQ-021 SHALL, when P=1, take the block carry-out directly from the block carry-in (skip path) and increment skip_cnt.
REQ-022 SHALL, when P=0, take the block carry-out from the ripple carry.
REQ-023 SHALL go to DONE after the last block (k = WIDTH/BLK_W-1); latency from the input handshake to out_valid_o is WIDTH/BLK_W+1 cycles.
REQ-024 SHALL, in DONE, hold out_valid_o=1 and keep sum_o, cout_o, ovf_o and skip_cnt_o stable until out_ready_i=1, then return to IDLE.
REQ-025 SHALL set ovf_o = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
REQ-026 SHALL produce sum_o equal to (a_i+b_i+cin_i) mod 2^WIDTH, with cout_o as the bit WIDTH of that sum.
REQ-027 SHALL ignore in_valid_i outside IDLE; operands presented in RUN or DONE are not captured.
REQ-028 SHALL allow a new capture no earlier than the cycle after the output handshake; there is no back-to-back overlap.

Reset
REQ-029 SHALL, on rst_ni=0, immediately enter IDLE and clear all outputs, the operand registers and the carry register: in_ready_o=1 after reset, out_valid_o=0, sum_o=0, cout_o=0, ovf_o=0, skip_cnt_o=0.
REQ-030 SHALL, when reset is asserted mid-RUN or mid-DONE, discard the operation in progress with no output handshake.

Structure
REQ-031 SHALL place the state enum, the default WIDTH/BLK_W constants and the G/K/P classification enum in a shared package, seq_skip_adder_pkg.
REQ-032 SHALL instantiate one combinational sub-module, skip_block: a BLK_W-bit ripple adder with a group-propagate skip mux producing sum bits, carry-out and P.

Verification
REQ-033 SHALL cover: a=5, b=3, cin=0 -> sum=8, cout=0, ovf=0, out_valid after 9 cycles.
REQ-034 SHALL cover: a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1, cout=0.
REQ-035 SHALL cover: a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0, skip_cnt=8 (all blocks propagate).
REQ-036 SHALL cover: a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
REQ-037 SHALL cover: out_ready_i held 0 for 5 cycles in DONE -> outputs stable and in_ready_o=0 throughout; a new in_valid_i is not captured.
REQ-038 SHALL cover: rst_ni pulsed low at RUN cycle 4 -> IDLE, all outputs 0, no out_valid_o pulse.
